// File: rtl/contador_ad_multicampo.sv
// contador_ad_multicampo: NF-field time counter for the clock/alarm datapath.
// Run mode advances field 0 on each 1 Hz tick with full carry ripple; adjust
// mode edits the field indexed by sel from PS/2 scan codes.
// Optional build macro CONTADOR_ADJ_CARRY_EN: adjust increments carry and
// adjust decrements borrow into the fields above sel.
module contador_ad_multicampo #(
  parameter int              NF      = 3,
  parameter int              W       = 6,
  parameter int              SW      = 2,
  parameter logic [NF*W-1:0] MAX_VEC = {6'd23, 6'd59, 6'd59},
  parameter logic [1:0]      EN_CODE = 2'd2,
  parameter logic [7:0]      ST_A    = 8'h6C,
  parameter logic [7:0]      ST_B    = 8'h75
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      en,
  input  logic [7:0]      estado,
  input  logic [7:0]      Cambio,
  input  logic            got_data,
  input  logic            tick,
  output logic [NF*W-1:0] Cuentas,
  output logic [SW-1:0]   sel,
  output logic            carry_out
);

  typedef enum logic [7:0] {
    KEY_UP   = 8'h73,
    KEY_DOWN = 8'h72,
    KEY_NEXT = 8'h6B,
    KEY_PREV = 8'h74
  } key_e;

  function automatic logic [W-1:0] max_of(input int i);
    return MAX_VEC[i*W +: W];
  endfunction

  logic            adjust;
  logic [NF*W-1:0] cnt_d;
  logic [SW-1:0]   sel_d;
  logic            carry_d;

  assign adjust = (en == EN_CODE) && ((estado == ST_A) || (estado == ST_B));

  // Next-state computation for all fields, the selector and the carry pulse.
  // NOTE: blocking assignments here model the ripple: each loop iteration must
  // see the carry/borrow left by the previous one within the same cycle.
  always_comb begin
    logic [W-1:0] f;
    logic         cy;
`ifdef CONTADOR_ADJ_CARRY_EN
    logic         bw;
    bw      = 1'b0;
`endif
    f       = '0;
    cy      = 1'b0;
    cnt_d   = Cuentas;
    sel_d   = sel;
    carry_d = 1'b0;
    if (adjust) begin
      if (got_data) begin
        case (Cambio)
          KEY_UP: begin
            for (int i = 0; i < NF; i++) begin
              f = Cuentas[i*W +: W];
              if (SW'(i) == sel) begin
`ifdef CONTADOR_ADJ_CARRY_EN
                cy = (f >= max_of(i));
`endif
                cnt_d[i*W +: W] = (f >= max_of(i)) ? '0 : f + 1'b1;
              end
`ifdef CONTADOR_ADJ_CARRY_EN
              else if (cy) begin
                cy              = (f >= max_of(i));
                cnt_d[i*W +: W] = cy ? '0 : f + 1'b1;
              end
`endif
            end
            carry_d = cy;
          end
          KEY_DOWN: begin
            for (int i = 0; i < NF; i++) begin
              f = Cuentas[i*W +: W];
              if (SW'(i) == sel) begin
`ifdef CONTADOR_ADJ_CARRY_EN
                bw = (f == '0);
`endif
                cnt_d[i*W +: W] = (f == '0) ? max_of(i) : f - 1'b1;
              end
`ifdef CONTADOR_ADJ_CARRY_EN
              else if (bw) begin
                bw              = (f == '0);
                cnt_d[i*W +: W] = bw ? max_of(i) : f - 1'b1;
              end
`endif
            end
          end
          KEY_NEXT: sel_d = (sel >= SW'(NF-1)) ? '0 : sel + 1'b1;
          KEY_PREV: sel_d = (sel == '0) ? SW'(NF-1) : sel - 1'b1;
          default:  ;
        endcase
      end
    end else if (tick) begin
      cy = 1'b1;
      for (int i = 0; i < NF; i++) begin
        f = Cuentas[i*W +: W];
        if (cy) begin
          if (f >= max_of(i)) begin
            cnt_d[i*W +: W] = '0;
          end else begin
            cnt_d[i*W +: W] = f + 1'b1;
            cy              = 1'b0;
          end
        end
      end
      carry_d = cy;
    end
  end

  // Output registers; synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      Cuentas   <= '0;
      sel       <= '0;
      carry_out <= 1'b0;
    end else begin
      Cuentas   <= cnt_d;
      sel       <= sel_d;
      carry_out <= carry_d;
    end
  end

endmodule

// File: tb/tb_contador_ad_multicampo.sv
// Directed self-checking bench for contador_ad_multicampo (default parameters).
// Expected values are hand-derived; the two macro-dependent adjust cases
// branch on CONTADOR_ADJ_CARRY_EN.
module tb_contador_ad_multicampo;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [7:0]  estado;
  logic [7:0]  Cambio;
  logic        got_data;
  logic        tick;
  logic [17:0] Cuentas;
  logic [1:0]  sel;
  logic        carry_out;

  int n_total = 0;
  int n_pass  = 0;

  contador_ad_multicampo dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .estado    (estado),
    .Cambio    (Cambio),
    .got_data  (got_data),
    .tick      (tick),
    .Cuentas   (Cuentas),
    .sel       (sel),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input int f2, input int f1, input int f0);
    return {6'(f2), 6'(f1), 6'(f0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are stable #1 after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] code);
    got_data = 1'b1;
    Cambio   = code;
    cyc();
    got_data = 1'b0;
    Cambio   = 8'h00;
  endtask

  task automatic enter_adjust();
    en     = 2'd2;
    estado = 8'h6C;
  endtask

  task automatic leave_adjust();
    en     = 2'd0;
    estado = 8'h00;
  endtask

  initial begin
    rst = 1'b1; en = 2'd0; estado = 8'h00; Cambio = 8'h00; got_data = 1'b0; tick = 1'b0;
    cyc(); cyc();
    check("reset_cuentas", 32'(Cuentas), 32'(pk(0, 0, 0)));
    check("reset_sel", 32'(sel), 0);
    check("reset_carry", 32'(carry_out), 0);
    rst = 1'b0;

    // 60 ticks in run mode -> 0:1:0, carry never raised
    for (int i = 0; i < 60; i++) begin
      tick = 1'b1;
      cyc();
      check("run60_carry", 32'(carry_out), 0);
    end
    tick = 1'b0;
    check("run60_cuentas", 32'(Cuentas), 32'(pk(0, 1, 0)));

    // Preload 59:59:23 using increments only (no wraps, macro-independent)
    enter_adjust();
    for (int i = 0; i < 59; i++) key(8'h73);
    check("preload_f0", 32'(Cuentas), 32'(pk(0, 1, 59)));
    key(8'h6B);
    check("sel_next_1", 32'(sel), 1);
    for (int i = 0; i < 58; i++) key(8'h73);
    key(8'h6B);
    for (int i = 0; i < 23; i++) key(8'h73);
    check("preload_all", 32'(Cuentas), 32'(pk(23, 59, 59)));
    check("preload_sel", 32'(sel), 2);

    // tick frozen in adjust; unknown code holds
    tick = 1'b1; cyc(); tick = 1'b0;
    check("adj_tick_frozen", 32'(Cuentas), 32'(pk(23, 59, 59)));
    check("adj_tick_nocarry", 32'(carry_out), 0);
    key(8'h1C);
    check("adj_1C_hold", 32'(Cuentas), 32'(pk(23, 59, 59)));
    check("adj_1C_sel", 32'(sel), 2);

    // Top field at max, increment -> 0; lower fields untouched
    key(8'h73);
    check("f2_wrap", 32'(Cuentas), 32'(pk(0, 59, 59)));
`ifdef CONTADOR_ADJ_CARRY_EN
    check("f2_wrap_carry", 32'(carry_out), 1);
`else
    check("f2_wrap_carry", 32'(carry_out), 0);
`endif
    cyc();
    check("carry_one_cycle", 32'(carry_out), 0);
    key(8'h72);
    check("f2_down_wrap", 32'(Cuentas), 32'(pk(23, 59, 59)));

    // Selector wrap in both directions
    key(8'h6B);
    check("sel_wrap_up", 32'(sel), 0);
    key(8'h74);
    check("sel_wrap_down", 32'(sel), 2);
    key(8'h6B); key(8'h6B);
    check("sel_twice_next", 32'(sel), 1);

    // Field 1 wrap: independent by default, ripple/borrow with macro
    key(8'h73);
`ifdef CONTADOR_ADJ_CARRY_EN
    check("f1_wrap", 32'(Cuentas), 32'(pk(0, 0, 59)));
    check("f1_wrap_carry", 32'(carry_out), 1);
`else
    check("f1_wrap", 32'(Cuentas), 32'(pk(23, 0, 59)));
    check("f1_wrap_carry", 32'(carry_out), 0);
`endif
    key(8'h72);
    check("f1_down_wrap", 32'(Cuentas), 32'(pk(23, 59, 59)));

    // Leave adjust, one tick -> full ripple to zero, single carry pulse
    leave_adjust();
    tick = 1'b1; cyc(); tick = 1'b0;
    check("ripple_zero", 32'(Cuentas), 32'(pk(0, 0, 0)));
    check("ripple_carry", 32'(carry_out), 1);
    cyc();
    check("ripple_carry_drop", 32'(carry_out), 0);

    // Run mode ignores got_data
    key(8'h73);
    check("run_ignore_key", 32'(Cuentas), 32'(pk(0, 0, 0)));
    check("run_sel_hold", 32'(sel), 1);

    // Tick coincident with entering adjust is dropped
    enter_adjust(); tick = 1'b1; cyc(); tick = 1'b0;
    check("enter_adj_tick", 32'(Cuentas), 32'(pk(0, 0, 0)));

    // Reset wins over a simultaneous adjust increment
    key(8'h73);
    check("pre_rst_state", 32'(Cuentas), 32'(pk(0, 1, 0)));
    rst = 1'b1; got_data = 1'b1; Cambio = 8'h73;
    cyc();
    rst = 1'b0; got_data = 1'b0; Cambio = 8'h00;
    check("rst_vs_key_cuentas", 32'(Cuentas), 32'(pk(0, 0, 0)));
    check("rst_vs_key_sel", 32'(sel), 0);
    check("rst_vs_key_carry", 32'(carry_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/contador_ad_multicampo.md
# contador_ad_multicampo

Parametrised multi-field time counter for the clock/alarm datapath. It holds NF packed fields (default seconds/minutes/hours), each wrapping at its own maximum. In run mode it advances from a 1 Hz `tick` with carry ripple between fields. In adjust mode it edits one user-selected field from PS/2 keypad scan codes, so a single instance replaces the separate per-field adjust counters.

## Interface
- `NF`, 3: number of fields; field 0 is least significant.
- `W`, 6: bits per field.
- `SW`, 2: width of `sel`; must satisfy 2^SW ≥ NF.
- `MAX_VEC`, {6'd23,6'd59,6'd59}: packed NF×W maxima; field i maximum is `MAX_VEC[i*W +: W]`.
- `EN_CODE`, 2'd2: value of `en` that permits adjust.
- `ST_A`, 8'h6C; `ST_B`, 8'h75: `estado` values that permit adjust.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  2  mode code from the top-level FSM.
- `estado`  in  8  current menu state code.
- `Cambio`  in  8  last received PS/2 scan code.
- `got_data`  in  1  scan-code-valid qualifier; each high cycle is one event.
- `tick`  in  1  single-cycle 1 Hz enable.
- `Cuentas`  out  NF*W  packed field values; field i is at `[i*W +: W]`; registered.
- `sel`  out  SW  index of the field being edited; registered.
- `carry_out`  out  1  one-cycle pulse when the top field wraps upward.

## Operation
- Adjust mode: `en==EN_CODE && (estado==ST_A || estado==ST_B)`. Run mode is every other condition.
- Adjust mode ignores `tick`, so time is frozen while editing. With `got_data` high, the scan code selects the action:
  - 8'h73: increment field `sel`. At a value ≥ its maximum, the field goes to 0.
  - 8'h72: decrement field `sel`. At 0, the field goes to its maximum.
  - 8'h6B: `sel` ← `sel`+1, wrapping from NF-1 to 0.
  - 8'h74: `sel` ← `sel`-1, wrapping from 0 to NF-1.
  - Any other code: hold all state.
- Without `ADJ_CARRY_EN`, an adjust operation changes only field `sel`; no other field changes.
- In adjust mode, `carry_out` stays 0 unless `ADJ_CARRY_EN` is defined.
- Run mode with `tick` high:
  - Field 0 increments.
  - Any field at ≥ its maximum wraps to 0 and increments field i+1 in the same cycle (full ripple in one clock).
  - If the top field wraps, `carry_out` = 1 for that cycle.
- Run mode ignores `got_data`; `sel` holds.
- Arithmetic is modulo per field. No field is ever written above its maximum, except that a parameter error can leave a field out of range; such a field recovers to 0 on its next increment.
- Reset (`rst`) clears every field, `sel`, and `carry_out` to 0. Reset overrides all other inputs, including during an adjust.

## Timing
- All outputs are registered. An event sampled at edge k appears on the outputs after edge k; latency is 1 cycle.
- `got_data` held high for n cycles produces n events. The upstream PS/2 block guarantees a single-cycle pulse.
- A mode change takes effect on the same edge it is sampled. A `tick` coincident with entering adjust mode is dropped.
- `carry_out` is high for exactly one cycle per wrap and is never high two cycles in a row.
- Full 59:59:23 → 0:0:0 ripple completes in one cycle.

## Configuration
- Macro `CONTADOR_ADJ_CARRY_EN`.
- Defined:
  - Adjust increment of field `sel` that wraps propagates a carry into fields above `sel`, using the same ripple as run mode. The top-field wrap pulses `carry_out`.
  - Adjust decrement at 0 propagates a borrow: each higher field at 0 goes to its maximum, otherwise it decrements. Borrow out of the top field is silently dropped.
- Undefined: fields wrap independently during adjust. Run-mode behaviour is identical in both builds.

## Test plan
- Reset then 60 ticks → fields (0,1,0), `carry_out` never high.
- Preload 59:59:23 via adjust, leave adjust, one tick → all fields 0, `carry_out` = 1 for exactly one cycle.
- Adjust mode, `sel`=2, field 2 = 23, code 8'h73 → field 2 = 0, fields 0 and 1 unchanged (macro undefined); field 2 = 0 with no change to fields 0 and 1 plus a `carry_out` pulse (macro defined).
- Adjust mode, `sel`=0, code 8'h74 → `sel`=2; then 8'h6B twice → `sel`=1.
- `tick` asserted during adjust and `got_data` with 8'h73 asserted in run mode → no state change in either case; code 8'h1C in adjust mode → hold.
- `rst` asserted in the same cycle as `got_data` with 8'h73 → all outputs 0 on the next cycle.
